// File: rtl/pipelined_kogge_stone_addsub_if.sv
// Stream bundle for the pipelined Kogge-Stone adder/subtractor: operand beat in,
// result beat out, each with its own valid/ready pair.
interface pipelined_kogge_stone_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow, zero
  );

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow, zero
  );
endinterface

// File: rtl/pipelined_kogge_stone_addsub.sv
// Fully pipelined Kogge-Stone adder/subtractor, one register per prefix level,
// with a single global advance that stalls every stage on output backpressure.
module pipelined_kogge_stone_addsub #(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  pipelined_kogge_stone_addsub_if.slave bus
);
  localparam int LEVELS  = $clog2(WIDTH);
  localparam int LATENCY = LEVELS + 1;

  logic [LEVELS:0]                vld_q;
  logic [LEVELS:0][WIDTH-1:0]     g_q, g_d;
  logic [LEVELS-1:0][WIDTH-1:0]   p_q, p_d;
  logic [LEVELS:0][WIDTH-1:0]     hs_q;
  logic [LEVELS:0]                c0_q;
  logic [LEVELS:0]                amsb_q;
  logic [LEVELS:0]                bmsb_q;

  logic             adv;
  logic [WIDTH-1:0] bp;
  logic             c0;
  logic [WIDTH-1:0] hs0;
  logic [WIDTH-1:0] sum_raw;
  logic             out_vld;

  assign out_vld = vld_q[LEVELS];
  assign adv     = ~out_vld | bus.out_ready;

  assign bp  = bus.sub ? ~bus.b : bus.b;
  assign c0  = bus.sub | bus.cin;
  assign hs0 = bus.a ^ bp;

  // Carry-in acts as generate at bit -1: merged into bit 0's group generate, so
  // bit 0 already spans [0:-1] and the tree of LEVELS levels covers every carry.
  assign g_d[0] = (bus.a & bp) | {{(WIDTH-1){1'b0}}, hs0[0] & c0};
  assign p_d[0] = {hs0[WIDTH-1:1], 1'b0};

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int D = 2 ** (k - 1);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= D) begin : g_node
        assign g_d[k][i] = g_q[k-1][i] | (p_q[k-1][i] & g_q[k-1][i-D]);
        if (k < LEVELS) begin : g_prop
          assign p_d[k][i] = p_q[k-1][i] & p_q[k-1][i-D];
        end
      end else begin : g_pass
        assign g_d[k][i] = g_q[k-1][i];
        if (k < LEVELS) begin : g_prop
          assign p_d[k][i] = p_q[k-1][i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      g_q    <= '0;
      p_q    <= '0;
      hs_q   <= '0;
      c0_q   <= '0;
      amsb_q <= '0;
      bmsb_q <= '0;
    end else if (adv) begin
      vld_q  <= {vld_q[LEVELS-1:0], bus.in_valid};
      g_q    <= g_d;
      p_q    <= p_d;
      hs_q   <= {hs_q[LEVELS-1:0], hs0};
      c0_q   <= {c0_q[LEVELS-1:0], c0};
      amsb_q <= {amsb_q[LEVELS-1:0], bus.a[WIDTH-1]};
      bmsb_q <= {bmsb_q[LEVELS-1:0], bp[WIDTH-1]};
    end
  end

  // Carry into bit i is the group generate of [i-1:-1]; into bit 0 it is c0 itself.
  assign sum_raw = hs_q[LEVELS] ^ {g_q[LEVELS][WIDTH-2:0], c0_q[LEVELS]};

  assign bus.in_ready  = adv;
  assign bus.out_valid = out_vld;
  assign bus.sum       = out_vld ? sum_raw : '0;
  assign bus.carry_out = out_vld & g_q[LEVELS][WIDTH-1];
  assign bus.overflow  = out_vld & (amsb_q[LEVELS] == bmsb_q[LEVELS])
                                 & (sum_raw[WIDTH-1] != amsb_q[LEVELS]);
  assign bus.zero      = out_vld & ~|sum_raw;

  if (LATENCY != LEVELS + 1) begin : g_never
    $error("latency derivation broken");
  end
endmodule

// File: tb/tb_pipelined_kogge_stone_addsub.sv
// Bench for the pipelined Kogge-Stone adder/subtractor at WIDTH=8 and WIDTH=13,
// scoring every consumed beat against an arithmetic reference queue.
module tb_pipelined_kogge_stone_addsub;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_kogge_stone_addsub_if #(.WIDTH(8))  if8();
  pipelined_kogge_stone_addsub_if #(.WIDTH(13)) if13();

  pipelined_kogge_stone_addsub #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  pipelined_kogge_stone_addsub #(.WIDTH(13)) u_dut13 (.clk(clk), .rst_n(rst_n), .bus(if13));

  typedef struct {
    longint sum;
    bit     co;
    bit     ov;
    bit     z;
  } exp_t;

  exp_t q8[$];
  exp_t q13[$];
  exp_t e8, e13;
  int   n_checks = 0;
  int   n_errors = 0;
  int   acc13 = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t ref_model(input int w, input longint a, input longint b,
                                     input bit cin, input bit sub);
    exp_t   e;
    longint m, full, sa, sb, sr;
    m = longint'(1) << w;
    if (sub) full = a - b + m;
    else     full = a + b + longint'(cin);
    e.sum = full % m;
    e.co  = (full >= m);
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    sr = sub ? sa - sb : sa + sb + longint'(cin);
    e.ov = (sr >= m / 2) || (sr < -(m / 2));
    e.z  = (e.sum == 0);
    return e;
  endfunction

  always @(negedge rst_n) begin
    q8.delete();
    q13.delete();
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (if8.in_valid && if8.in_ready)
        q8.push_back(ref_model(8, longint'(if8.a), longint'(if8.b), if8.cin, if8.sub));
      if (!if8.out_valid)
        check_val("w8 idle_outs", {if8.sum, if8.carry_out, if8.overflow, if8.zero}, 0);
      else if (if8.out_ready) begin
        if (q8.size() == 0) check_val("w8 spurious_out", if8.out_valid, 0);
        else begin
          e8 = q8.pop_front();
          check_val("w8 sum", longint'(if8.sum), e8.sum);
          check_val("w8 flags", {if8.carry_out, if8.overflow, if8.zero}, {e8.co, e8.ov, e8.z});
        end
      end
      if (if13.in_valid && if13.in_ready) begin
        q13.push_back(ref_model(13, longint'(if13.a), longint'(if13.b), if13.cin, if13.sub));
        acc13++;
      end
      if (!if13.out_valid)
        check_val("w13 idle_outs", {if13.sum, if13.carry_out, if13.overflow, if13.zero}, 0);
      else if (if13.out_ready) begin
        if (q13.size() == 0) check_val("w13 spurious_out", if13.out_valid, 0);
        else begin
          e13 = q13.pop_front();
          check_val("w13 sum", longint'(if13.sum), e13.sum);
          check_val("w13 flags", {if13.carry_out, if13.overflow, if13.zero}, {e13.co, e13.ov, e13.z});
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the edge that accepted the beat.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input bit cin, input bit sub);
    int n = 0;
    bit ok = 1'b0;
    if8.in_valid = 1'b1; if8.a = a; if8.b = b; if8.cin = cin; if8.sub = sub;
    do begin
      @(negedge clk); ok = if8.in_ready;
      @(posedge clk); #1; n++;
    end while (!ok && n < 60);
    if (!ok) check_val("w8 send_timeout", ok, 1);
  endtask

  task automatic send13(input logic [12:0] a, input logic [12:0] b, input bit cin, input bit sub);
    int n = 0;
    bit ok = 1'b0;
    if13.in_valid = 1'b1; if13.a = a; if13.b = b; if13.cin = cin; if13.sub = sub;
    do begin
      @(negedge clk); ok = if13.in_ready;
      @(posedge clk); #1; n++;
    end while (!ok && n < 60);
    if (!ok) check_val("w13 send_timeout", ok, 1);
  endtask

  task automatic wait_out8(output int cyc);
    cyc = 0;
    while (!if8.out_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
  endtask

  task automatic wait_out13(output int cyc);
    cyc = 0;
    while (!if13.out_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int cyc, n;
    if8.in_valid = 0;  if8.a = 0;  if8.b = 0;  if8.cin = 0;  if8.sub = 0;  if8.out_ready = 1;
    if13.in_valid = 0; if13.a = 0; if13.b = 0; if13.cin = 0; if13.sub = 0; if13.out_ready = 1;

    #1;
    check_val("w8 reset_outs", {if8.out_valid, if8.sum, if8.carry_out, if8.overflow, if8.zero}, 0);
    check_val("w13 reset_outs", {if13.out_valid, if13.sum, if13.carry_out, if13.overflow, if13.zero}, 0);
    check_val("w8 reset_in_ready", if8.in_ready, 1);
    cycles(3);
    rst_n = 1'b1;
    cycles(2);

    // LATENCY=4 cycles from presentation: 3 further edges after the accepting one.
    send8(8'hFF, 8'h01, 1'b0, 1'b0); if8.in_valid = 0;
    wait_out8(cyc);
    check_val("w8 latency", cyc, 3);
    check_val("w8 ff+01 sum", if8.sum, 8'h00);
    check_val("w8 ff+01 co/ov/z", {if8.carry_out, if8.overflow, if8.zero}, 3'b101);
    cycles(1);

    send8(8'h7F, 8'h00, 1'b1, 1'b0); if8.in_valid = 0;
    wait_out8(cyc);
    check_val("w8 7f+0+1 sum", if8.sum, 8'h80);
    check_val("w8 7f+0+1 co/ov/z", {if8.carry_out, if8.overflow, if8.zero}, 3'b010);
    cycles(1);

    send8(8'h05, 8'h07, 1'b1, 1'b1); if8.in_valid = 0;
    wait_out8(cyc);
    check_val("w8 05-07 sum", if8.sum, 8'hFE);
    check_val("w8 05-07 co/ov/z", {if8.carry_out, if8.overflow, if8.zero}, 3'b000);
    cycles(3);

    fork
      begin
        for (int i = 0; i < 16; i++)
          send8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        if8.in_valid = 0;
      end
      begin
        wait_out8(cyc);
        for (int i = 0; i < 16; i++) begin
          check_val("w8 stream_valid", if8.out_valid, 1);
          cycles(1);
        end
        check_val("w8 stream_end", if8.out_valid, 0);
      end
    join
    cycles(2);

    if8.out_ready = 0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        if8.in_valid = 0;
      end
      begin
        wait_out8(cyc);
        for (int i = 0; i < 6; i++) begin
          check_val("w8 bp_in_ready", if8.in_ready, 0);
          if (q8.size() > 0) check_val("w8 bp_sum", longint'(if8.sum), q8[0].sum);
          else check_val("w8 bp_spurious", if8.out_valid, 0);
          cycles(1);
        end
        if8.out_ready = 1;
      end
    join
    n = 0;
    while (q8.size() > 0 && n < 40) begin cycles(1); n++; end
    check_val("w8 bp_drain", q8.size(), 0);
    cycles(2);

    for (int i = 0; i < 3; i++)
      send8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    if8.in_valid = 0;
    cycles(1);
    check_val("w8 pre_reset_valid", if8.out_valid, 1);
    rst_n = 1'b0;
    #1;
    check_val("w8 async_reset_outs", {if8.out_valid, if8.sum, if8.carry_out, if8.overflow, if8.zero}, 0);
    cycles(2);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check_val("w8 no_stale_valid", if8.out_valid, 0);
      cycles(1);
    end

    n = 0;
    while (n < 1500) begin
      if8.in_valid = ($urandom_range(0, 3) != 0);
      if8.a = 8'($urandom); if8.b = 8'($urandom);
      if8.cin = 1'($urandom); if8.sub = 1'($urandom);
      if8.out_ready = ($urandom_range(0, 3) != 0);
      cycles(1); n++;
    end
    if8.in_valid = 0; if8.out_ready = 1;

    send13(13'h1FFF, 13'h0001, 1'b0, 1'b0); if13.in_valid = 0;
    wait_out13(cyc);
    check_val("w13 latency", cyc, 4);
    check_val("w13 1fff+1 sum", if13.sum, 13'h0000);
    check_val("w13 1fff+1 co/z", {if13.carry_out, if13.zero}, 2'b11);
    cycles(2);

    n = 0;
    cyc = acc13;
    while ((acc13 - cyc) < 10000 && n < 40000) begin
      if13.in_valid = ($urandom_range(0, 7) != 0);
      if13.a = 13'($urandom); if13.b = 13'($urandom);
      if13.cin = 1'($urandom); if13.sub = 1'($urandom);
      if13.out_ready = ($urandom_range(0, 3) != 0);
      cycles(1); n++;
    end
    check_val("w13 random_volume_reached", ((acc13 - cyc) >= 10000) ? 1 : 0, 1);
    if13.in_valid = 0; if13.out_ready = 1;

    n = 0;
    while ((q8.size() > 0 || q13.size() > 0) && n < 50) begin cycles(1); n++; end
    check_val("w8 final_drain", q8.size(), 0);
    check_val("w13 final_drain", q13.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
